// File: rtl/ch_readout_collector.sv
// Initiator for the per-channel serial readout: reads trigger_cnt, then the valid
// timestamp registers, and hands each deserialized word to a valid/ready consumer.
module ch_readout_collector #(
  parameter int WORD_W       = 10,
  parameter int LOAD_LATENCY = 1,
  parameter int MAX_TS       = 5
) (
  input  logic              SPI_CLK,
  input  logic              RSTB,
  input  logic              START,
  input  logic              ABORT,
  output logic              INST_READOUT,
  output logic [2:0]        SELECT_REG,
  input  logic              CNT_SER,
  output logic [WORD_W-1:0] WORD_DATA,
  output logic [2:0]        WORD_TAG,
  output logic              WORD_VALID,
  input  logic              WORD_READY,
  output logic              BUSY,
  output logic              DONE
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [2:0] TAG_CNT  = 3'd5;
  localparam logic [2:0] MAX_TS_L = 3'(MAX_TS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_PUSH} state_t;

  state_t            r_state;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [1:0]        r_load_cnt;
  logic [WORD_W-1:0] r_shreg;
  logic [WORD_W-1:0] r_word_data;
  logic [2:0]        r_word_tag;
  logic              r_word_valid;
  logic              r_inst;
  logic [2:0]        r_sel;
  logic              r_busy;
  logic              r_done;
  logic [2:0]        r_n_ts;
  logic [2:0]        r_ts_idx;

  logic [WORD_W-1:0] w_shift_word;
  logic              w_tag_is_cnt;
  logic [2:0]        w_trig_n;
  logic [2:0]        w_n_ts_nx;
  logic [2:0]        w_idx_nx;
  logic              w_more;

  assign w_shift_word = {r_shreg[WORD_W-2:0], CNT_SER};
  assign w_tag_is_cnt = (r_word_tag == TAG_CNT);
  // Only the low three bits of trigger_cnt matter; anything past CE is clamped.
  assign w_trig_n     = (r_word_data[2:0] > MAX_TS_L) ? MAX_TS_L : r_word_data[2:0];
  assign w_n_ts_nx    = w_tag_is_cnt ? w_trig_n : r_n_ts;
  assign w_idx_nx     = w_tag_is_cnt ? 3'd0 : r_ts_idx;
  assign w_more       = (w_idx_nx < w_n_ts_nx);

  always_ff @(posedge SPI_CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_load_cnt   <= '0;
      r_shreg      <= '0;
      r_word_data  <= '0;
      r_word_tag   <= '0;
      r_word_valid <= 1'b0;
      r_inst       <= 1'b0;
      r_sel        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_n_ts       <= '0;
      r_ts_idx     <= '0;
    end else begin
      r_done <= 1'b0;
      if (ABORT && (r_state != S_IDLE)) begin
        r_state      <= S_IDLE;
        r_inst       <= 1'b0;
        r_word_valid <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // A START coinciding with DONE is dropped; ABORT also masks START.
            if (START && !ABORT && !r_done) begin
              r_sel      <= TAG_CNT;
              r_inst     <= 1'b1;
              r_busy     <= 1'b1;
              r_bit_cnt  <= '0;
              r_load_cnt <= '0;
              r_state    <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (r_load_cnt == 2'(LOAD_LATENCY)) begin
              r_bit_cnt <= '0;
              r_state   <= S_SHIFT;
            end else begin
              r_load_cnt <= r_load_cnt + 2'd1;
            end
          end
          S_SHIFT: begin
            r_shreg   <= w_shift_word;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == BC_W'(WORD_W-1)) begin
              r_word_data  <= w_shift_word;
              r_word_tag   <= r_sel;
              r_word_valid <= 1'b1;
              r_inst       <= 1'b0;
              r_state      <= S_PUSH;
            end
          end
          S_PUSH: begin
            if (r_word_valid && WORD_READY) begin
              r_word_valid <= 1'b0;
              r_n_ts       <= w_n_ts_nx;
              if (w_more) begin
                r_sel      <= w_idx_nx;
                r_ts_idx   <= w_idx_nx + 3'd1;
                r_inst     <= 1'b1;
                r_load_cnt <= '0;
                r_state    <= S_LOAD;
              end else begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign INST_READOUT = r_inst;
  assign SELECT_REG   = r_sel;
  assign WORD_DATA    = r_word_data;
  assign WORD_TAG     = r_word_tag;
  assign WORD_VALID   = r_word_valid;
  assign BUSY         = r_busy;
  assign DONE         = r_done;

endmodule
